// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I pipeline hazard controller (stall/flush/bubble, forwarding selects, stall counter).
// Define HAZARD_CTRL_FORWARD_EN for EX/MEM + MEM/WB forwarding; default build stalls on every RAW.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_writes_rd,
   input  logic             id_is_load,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush,
   output logic             ex_valid,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);
   logic [4:0] ex_rd, mem_rd;
   logic       ex_wr, mem_v, mem_wr;
   logic       p_ex, p_mem, ma_ex, mb_ex, ma_mem, mb_mem, hazard, bubble;

   // The WB slot is never consulted: the write-first regfile covers it.
   assign p_ex   = ex_valid & ex_wr & (ex_rd != 5'd0);
   assign p_mem  = mem_v & mem_wr & (mem_rd != 5'd0);
   assign ma_ex  = id_uses_rs1 & id_valid & p_ex & (ex_rd == id_rs1);
   assign mb_ex  = id_uses_rs2 & id_valid & p_ex & (ex_rd == id_rs2);
   assign ma_mem = id_uses_rs1 & id_valid & p_mem & (mem_rd == id_rs1);
   assign mb_mem = id_uses_rs2 & id_valid & p_mem & (mem_rd == id_rs2);
   assign flush  = ex_valid & ex_branch_taken;
   assign stall  = hazard & ~flush & ~reset;
   assign bubble = stall | flush;

`ifdef HAZARD_CTRL_FORWARD_EN
   logic ex_ld;
   assign hazard = ex_ld & (ma_ex | mb_ex);
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_ld <= 1'b0;
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else begin
         ex_ld <= id_is_load;
         fwd_a <= bubble ? 2'b00 : ma_ex ? 2'b01 : ma_mem ? 2'b10 : 2'b00;
         fwd_b <= bubble ? 2'b00 : mb_ex ? 2'b01 : mb_mem ? 2'b10 : 2'b00;
      end
   end
`else
   logic unused_load;
   assign unused_load = &{1'b0, id_is_load};
   assign hazard = ma_ex | mb_ex | ma_mem | mb_mem;
   assign fwd_a  = 2'b00;
   assign fwd_b  = 2'b00;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         ex_rd       <= 5'd0;
         ex_wr       <= 1'b0;
         mem_v       <= 1'b0;
         mem_rd      <= 5'd0;
         mem_wr      <= 1'b0;
         stall_count <= '0;
      end else begin
         mem_v    <= ex_valid;
         mem_rd   <= ex_rd;
         mem_wr   <= ex_wr;
         ex_valid <= id_valid & ~bubble;
         ex_rd    <= id_rd;
         ex_wr    <= id_writes_rd;
         if (stall && !(&stall_count))
            stall_count <= stall_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl; expectations follow HAZARD_CTRL_FORWARD_EN.
module tb_hazard_ctrl;
`ifdef HAZARD_CTRL_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   localparam int S = FWD ? 1 : 2;

   logic        clk = 1'b0;
   logic        reset, id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load, ex_branch_taken;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        stall, flush, ex_valid, stall2, flush2, ex_valid2;
   logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2, cnt2;
   logic [15:0] stall_count;
   int          vectors = 0, miscompares = 0, e, base;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
      .stall(stall), .flush(flush), .ex_valid(ex_valid), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_count(stall_count)
   );

   hazard_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
      .stall(stall2), .flush(flush2), .ex_valid(ex_valid2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
      .stall_count(cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setid(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
      id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
      id_rd = rd; id_writes_rd = wr; id_is_load = ld;
      #1;
   endtask

   task automatic drain();
      setid(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   initial begin
      reset = 1'b1; ex_branch_taken = 1'b0;
      setid(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) step();
      chk("rst_stall", stall, 0);
      chk("rst_flush", flush, 0);
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_fwd_b", fwd_b, 0);
      chk("rst_count", stall_count, 0);
      reset = 1'b0;
      step();
      // add x1,x2,x3 ; addi x4,x1,8
      setid(1, 2, 1, 3, 1, 1, 1, 0);
      chk("alu_p_stall", stall, 0);
      step();
      setid(1, 1, 1, 8, 0, 4, 1, 0);
      if (FWD) begin
         chk("alu_stall_f", stall, 0);
         step();
         chk("alu_exv_f", ex_valid, 1);
         chk("alu_fwd_a_f", fwd_a, 1);
         chk("alu_cnt_f", stall_count, 0);
      end else begin
         chk("alu_stall1", stall, 1);
         step();
         chk("alu_bub1", ex_valid, 0);
         chk("alu_stall2", stall, 1);
         step();
         chk("alu_bub2", ex_valid, 0);
         chk("alu_stall3", stall, 0);
         step();
         chk("alu_exv", ex_valid, 1);
         chk("alu_fwd_a", fwd_a, 0);
         chk("alu_cnt", stall_count, 2);
      end
      drain();
      // lw x1,8(x2) ; add x5,x1,x1
      setid(1, 2, 1, 0, 0, 1, 1, 1);
      chk("lu_p_stall", stall, 0);
      step();
      setid(1, 1, 1, 1, 1, 5, 1, 0);
      for (int j = 0; j < S; j++) begin
         chk("lu_stall", stall, 1);
         step();
         chk("lu_bubble", ex_valid, 0);
      end
      chk("lu_release", stall, 0);
      step();
      chk("lu_exv", ex_valid, 1);
      chk("lu_fwd_a", fwd_a, FWD ? 2 : 0);
      chk("lu_fwd_b", fwd_b, FWD ? 2 : 0);
      chk("lu_cnt", stall_count, FWD ? 1 : 4);
      drain();
      // lui x0,10 ; addi x1,x0,1
      setid(1, 0, 0, 0, 0, 0, 1, 0);
      step();
      setid(1, 0, 1, 1, 0, 1, 1, 0);
      chk("x0_stall", stall, 0);
      step();
      chk("x0_exv", ex_valid, 1);
      chk("x0_fwd_a", fwd_a, 0);
      drain();
      // taken branch in EX against a load-use hazard in ID
      base = FWD ? 1 : 4;
      setid(1, 2, 1, 0, 0, 1, 1, 1);
      step();
      setid(1, 1, 1, 1, 1, 5, 1, 0);
      ex_branch_taken = 1'b1;
      #1;
      chk("br_flush", flush, 1);
      chk("br_stall", stall, 0);
      step();
      chk("br_bubble", ex_valid, 0);
      chk("br_cnt", stall_count, base);
      setid(0, 0, 0, 0, 0, 0, 0, 0);
      chk("br_inv_flush", flush, 0);
      ex_branch_taken = 1'b0;
      drain();
      // reset asserted during a stall
      setid(1, 2, 1, 0, 0, 1, 1, 1);
      step();
      setid(1, 1, 1, 1, 1, 5, 1, 0);
      chk("rs_stall_pre", stall, 1);
      reset = 1'b1;
      #1;
      chk("rs_stall_drop", stall, 0);
      chk("rs_flush", flush, 0);
      step();
      chk("rs_exv", ex_valid, 0);
      chk("rs_cnt", stall_count, 0);
      chk("rs_cnt2", cnt2, 0);
      reset = 1'b0;
      drain();
      // chain of dependent loads on the 2-bit counter: 1, 2, 3, 3, ...
      e = 0;
      setid(1, 2, 1, 0, 0, 1, 1, 1);
      step();
      for (int k = 1; k <= 4; k++) begin
         setid(1, 5'(k), 1, 0, 0, 5'(k + 1), 1, 1);
         for (int j = 0; j < S; j++) begin
            chk("sat_stall", stall, 1);
            step();
            e = (e < 3) ? e + 1 : 3;
            chk("sat_cnt2", cnt2, e);
         end
         chk("sat_release", stall, 0);
         step();
      end
      chk("sat_cnt16", stall_count, 4 * S);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It tracks the destination registers of instructions in EX, MEM and WB, and compares them against the source registers decoded by `id_stage`. From that it issues stall, flush and bubble control to the IF/ID and ID/EX pipeline registers, plus registered forwarding selects for the EX-stage operand muxes. It also keeps a saturating stall-cycle counter for performance observation.

## Interface
Parameters:
- `CNT_W`, 16, width of the stall-cycle counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register indices from decode.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  instruction reads that source.
- `id_rd`  in  5  destination register index.
- `id_writes_rd`  in  1  instruction writes `rd`.
- `id_is_load`  in  1  instruction is a load (LW).
- `ex_branch_taken`  in  1  the EX instruction redirects the PC this cycle.
- `stall`  out  1  hold PC and IF/ID; combinational.
- `flush`  out  1  kill IF/ID contents; combinational.
- `ex_valid`  out  1  ID/EX holds a real instruction; registered.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 = regfile, 01 = MEM-stage result, 10 = WB-stage result; 11 is never driven; registered.
- `stall_count`  out  `CNT_W`  saturating count of stalled cycles; registered.

## Operation
Internal state:
- Slots EX, MEM and WB. Each slot holds {valid, rd, wr, load}.
- A slot is a producer only when valid=1, wr=1 and rd≠0.

Match rule:
- `m(S, rs, use)` = use & id_valid & S is a producer & S.rd==rs.

Hazard:
- With `FORWARD_EN`: hazard = m(EX,rs1) | m(EX,rs2), counted only when EX.load=1 (load-use).
- Without `FORWARD_EN`: hazard = any match against the EX or MEM slot.
- The WB slot never causes a hazard, because the register file is write-first (same-cycle bypass).

Outputs:
- `flush` = EX.valid & `ex_branch_taken`.
- `stall` = hazard & ~flush & ~reset. Flush has priority, since the ID instruction is squashed anyway.

Slot update on each rising edge, when reset is low:
- WB ← MEM, and MEM ← EX, unconditionally.
- EX ← bubble (valid=0) if stall or flush.
- Otherwise EX ← {id_valid, id_rd, id_writes_rd, id_is_load}.
- `ex_valid` mirrors EX.valid.

Forwarding selects, registered on the same edge that loads EX:
- `fwd_a` ← 01 if m(EX,rs1); else 10 if m(MEM,rs1); else 00. The nearest producer wins.
- `fwd_b` uses the same rule with rs2.
- The selects are forced to 00 when EX is loaded with a bubble.
- Without `FORWARD_EN`, both selects stay constant 00.

Counter:
- `stall_count` increments on every edge where `stall`=1.
- It saturates at all-ones and does not wrap.

Reset:
- All slots become invalid; `ex_valid`, `fwd_a`, `fwd_b` and `stall_count` become 0.
- `stall`=0 and `flush`=0 while reset is high.
- Reset asserted mid-stall drops the stall in the same cycle and discards all in-flight state.

## Timing
- `stall` and `flush` are combinational from the ID inputs, `ex_branch_taken` and the slot state, valid in the same cycle.
- `fwd_*` and `ex_valid` are valid in the cycle the instruction occupies EX, one edge after the ID decision.
- Load-use stall with forwarding:
  - Exactly 1 stall cycle.
  - On the next cycle the load sits in MEM, the consumer issues, and it receives `fwd`=10.
- Without forwarding:
  - 2 stall cycles when the producer is in EX.
  - 1 stall cycle when the producer is in MEM.
- Branch:
  - `flush` is high for 1 cycle.
  - EX receives 1 bubble.
  - `ex_branch_taken` with EX.valid=0 is ignored.
- Simultaneous hazard and flush: `stall`=0, `flush`=1, the counter does not increment.

## Configuration
- `HAZARD_CTRL_FORWARD_EN` defined:
  - Full EX/MEM and MEM/WB forwarding.
  - Only load-use hazards stall.
- `HAZARD_CTRL_FORWARD_EN` undefined:
  - No forwarding logic; `fwd_a` and `fwd_b` are tied to 00.
  - Any RAW dependence on an EX or MEM producer stalls until the producer reaches WB.

## Test plan
- Reset held 2 cycles → `stall`=0, `flush`=0, `ex_valid`=0, `fwd_a`=`fwd_b`=00, `stall_count`=0. Repeat with `reset` asserted during an active stall → stall drops in that cycle.
- Back-to-back dependent ALU ops, `add x1,x2,x3` then `addi x4,x1,8`:
  - Forwarding build: no stall; second op in EX sees `fwd_a`=01.
  - Non-forwarding build: `stall` high 2 cycles; `stall_count`=2.
- Load-use, `lw x1,8(x2)` then `add x5,x1,x1` (forwarding build) → `stall`=1 for exactly one cycle; one bubble (`ex_valid`=0); the add then enters EX with `fwd_a`=`fwd_b`=10.
- Writes to x0: `lui x0,10` then `addi x1,x0,1` → no stall, `fwd_a`=00, in both builds.
- `ex_branch_taken`=1 while EX valid and ID has a load-use hazard → `flush`=1, `stall`=0, EX gets a bubble, `stall_count` unchanged. `ex_branch_taken`=1 with EX invalid → `flush`=0.
- `CNT_W`=2 with a continuous hazard source → count reads 1, 2, 3, 3 (saturates, no wrap).
